// File: rtl/pulse_pkg.sv
// Shared constants and width helper for sampled trigger stages.
// Consumed by pulse_debounce_one and the pulse-inhibit stage.
package pulse_pkg;

   localparam int SAMPLE_DIV_DEF  = 1000;
   localparam int STABLE_CNT_DEF  = 8;
   localparam int REPEAT_DLY_DEF  = 50;
   localparam int REPEAT_RATE_DEF = 10;

   function automatic int clog2w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider producing a one-cycle TICK every SAMPLE_DIV clocks.
// Shared by every sampled stage in the codebase.
module tick_prescaler
   import pulse_pkg::*;
#(
   parameter int SAMPLE_DIV = SAMPLE_DIV_DEF
) (
   input  logic CLK,
   input  logic R,
   output logic TICK
);

   localparam int W = clog2w(SAMPLE_DIV);
   localparam logic [W-1:0] LAST = W'(SAMPLE_DIV - 1);

   logic [W-1:0] cnt_q, cnt_d;

   assign TICK  = (cnt_q == LAST);
   assign cnt_d = TICK ? '0 : cnt_q + W'(1);

   always_ff @(posedge CLK or negedge R) begin
      if (!R) cnt_q <= '0;
      else    cnt_q <= cnt_d;
   end

endmodule

// File: rtl/pulse_debounce_one.sv
// Synchronize, debounce and edge-detect a raw switch into TRG_ONE.
// Define PULSE_REPEAT_EN to add auto-repeat pulses while held.
module pulse_debounce_one
   import pulse_pkg::*;
#(
   parameter int SAMPLE_DIV  = SAMPLE_DIV_DEF,
   parameter int STABLE_CNT  = STABLE_CNT_DEF,
   parameter int REPEAT_DLY  = REPEAT_DLY_DEF,
   parameter int REPEAT_RATE = REPEAT_RATE_DEF
) (
   input  logic CLK,
   input  logic R,
   input  logic SW_IN,
   output logic TRG_ONE,
   output logic SW_LEVEL
);

   localparam int CW = clog2w(STABLE_CNT);
   localparam logic [CW-1:0] CMAX = CW'(STABLE_CNT - 1);

   logic          tick;
   logic          meta_q, sync_q;
   logic [CW-1:0] stab_q, stab_d;
   logic          level_q, level_d;
   logic          trg_q, trg_d;
   logic          differ, accept, press, fall;

   tick_prescaler #(
      .SAMPLE_DIV(SAMPLE_DIV)
   ) u_presc (
      .CLK (CLK),
      .R   (R),
      .TICK(tick)
   );

   assign differ  = sync_q ^ level_q;
   assign accept  = tick && differ && (stab_q == CMAX);
   assign press   = accept && !level_q;
   assign fall    = accept && level_q;
   assign level_d = level_q ^ accept;

   always_comb begin
      stab_d = stab_q;
      if (tick) begin
         if (!differ || accept) stab_d = '0;
         else                   stab_d = stab_q + CW'(1);
      end
   end

`ifdef PULSE_REPEAT_EN
   localparam int RW = clog2w(max_int(REPEAT_DLY, REPEAT_RATE));
   localparam logic [RW-1:0] DLY_LAST  = RW'(REPEAT_DLY - 1);
   localparam logic [RW-1:0] RATE_LAST = RW'(REPEAT_RATE - 1);

   logic [RW-1:0] rep_q, rep_d;
   logic          first_q, first_d;
   logic          rep_hit;

   assign rep_hit = tick && level_q && !fall &&
                    (rep_q == (first_q ? DLY_LAST : RATE_LAST));

   always_comb begin
      rep_d   = rep_q;
      first_d = first_q;
      if (!level_q || fall) begin
         rep_d   = '0;
         first_d = 1'b1;
      end else if (tick) begin
         if (rep_hit) begin
            rep_d   = '0;
            first_d = 1'b0;
         end else begin
            rep_d = rep_q + RW'(1);
         end
      end
   end

   always_ff @(posedge CLK or negedge R) begin
      if (!R) begin
         rep_q   <= '0;
         first_q <= 1'b1;
      end else begin
         rep_q   <= rep_d;
         first_q <= first_d;
      end
   end

   // With tick every cycle a repeat could land right after a pulse.
   assign trg_d = press || (rep_hit && !trg_q);
`else
   logic unused_rep;
   assign unused_rep = (REPEAT_DLY > 0) ^ (REPEAT_RATE > 0);
   assign trg_d      = press;
`endif

   always_ff @(posedge CLK or negedge R) begin
      if (!R) begin
         meta_q  <= 1'b0;
         sync_q  <= 1'b0;
         stab_q  <= '0;
         level_q <= 1'b0;
         trg_q   <= 1'b0;
      end else begin
         meta_q  <= SW_IN;
         sync_q  <= meta_q;
         stab_q  <= stab_d;
         level_q <= level_d;
         trg_q   <= trg_d;
      end
   end

   assign TRG_ONE  = trg_q;
   assign SW_LEVEL = level_q;

endmodule

// File: tb/tb_pulse_debounce_one.sv
// Scoreboard bench for pulse_debounce_one: expected pulse windows
// are queued by the stimulus and popped by per-instance monitors.
module tb_pulse_debounce_one;

   typedef struct {
      int lo;
      int hi;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic sw_a = 1'b0, sw_b = 1'b0, sw_c = 1'b0;
   logic trg_a, lvl_a, trg_b, lvl_b, trg_c, lvl_c;

   int cyc = 0;
   int rel = 0;
   int checks = 0;
   int errors = 0;

   exp_t q_a[$];
   exp_t q_b[$];
   exp_t q_c[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   pulse_debounce_one #(
      .SAMPLE_DIV(4), .STABLE_CNT(3),
      .REPEAT_DLY(1000), .REPEAT_RATE(1000)
   ) dut_a (
      .CLK(clk), .R(rst_n), .SW_IN(sw_a),
      .TRG_ONE(trg_a), .SW_LEVEL(lvl_a)
   );

   pulse_debounce_one #(
      .SAMPLE_DIV(1), .STABLE_CNT(1),
      .REPEAT_DLY(1000), .REPEAT_RATE(1000)
   ) dut_b (
      .CLK(clk), .R(rst_n), .SW_IN(sw_b),
      .TRG_ONE(trg_b), .SW_LEVEL(lvl_b)
   );

   pulse_debounce_one #(
      .SAMPLE_DIV(4), .STABLE_CNT(3),
      .REPEAT_DLY(5), .REPEAT_RATE(2)
   ) dut_c (
      .CLK(clk), .R(rst_n), .SW_IN(sw_c),
      .TRG_ONE(trg_c), .SW_LEVEL(lvl_c)
   );

   task automatic chk(input string nm, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d (cycle %0d)",
                  nm, got, exp, cyc);
      end
   endtask

   task automatic judge(input string nm, input bit have,
                        input exp_t e, input logic lvl);
      checks++;
      if (!have) begin
         errors++;
         $display("FAIL %s: unexpected pulse at cycle %0d, required none",
                  nm, cyc);
      end else if (cyc < e.lo || cyc > e.hi || lvl !== 1'b1) begin
         errors++;
         $display("FAIL %s: pulse at cycle %0d level %0b, required %0d..%0d level 1",
                  nm, cyc, lvl, e.lo, e.hi);
      end
   endtask

   exp_t ea, eb, ec;
   bit ha, hb, hc;

   always @(negedge clk) begin
      if (trg_a === 1'b1) begin
         ha = q_a.size() > 0;
         if (ha) ea = q_a.pop_front();
         judge("press_a", ha, ea, lvl_a);
      end
      if (trg_b === 1'b1) begin
         hb = q_b.size() > 0;
         if (hb) eb = q_b.pop_front();
         judge("press_b", hb, eb, lvl_b);
      end
      if (trg_c === 1'b1) begin
         hc = q_c.size() > 0;
         if (hc) ec = q_c.pop_front();
         judge("press_c", hc, ec, lvl_c);
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push_a(input int lo, input int hi);
      exp_t e;
      e.lo = lo;
      e.hi = hi;
      q_a.push_back(e);
   endtask

   task automatic push_b(input int lo, input int hi);
      exp_t e;
      e.lo = lo;
      e.hi = hi;
      q_b.push_back(e);
   endtask

   task automatic push_c(input int lo, input int hi);
      exp_t e;
      e.lo = lo;
      e.hi = hi;
      q_c.push_back(e);
   endtask

   task automatic release_rst();
      rst_n = 1'b1;
      rel = cyc;
   endtask

   // First prescaler tick edge at or after cycle c (DIV=4 instances).
   function automatic int next_tick(input int c);
      int t = rel + 4;
      while (t < c) t += 4;
      return t;
   endfunction

   task automatic bounce_a(input int n);
      for (int i = 0; i < n; i++) begin
         step(3);
         sw_a = ~sw_a;
      end
   endtask

   initial begin
      int e, f, p, u, fall_t;

      step(2);
      for (int i = 0; i < 8; i++) begin
         sw_a = ~sw_a;
         step(1);
         chk("rst_lvl_a", int'(lvl_a), 0);
         chk("rst_trg_a", int'(trg_a), 0);
      end

      sw_a = 1'b1;
      step(1);
      release_rst();
      push_a(rel + 11, rel + 15);
      step(20);
      chk("held_rst_lvl", int'(lvl_a), 1);
      chk("held_rst_pend", q_a.size(), 0);

      sw_a = 1'b0;
      step(60);
      chk("rel1_lvl", int'(lvl_a), 0);

      sw_a = 1'b1;
      e = cyc;
      push_a(e + 11, e + 15);
      step(10);
      chk("press_early_lvl", int'(lvl_a), 0);
      step(50);
      chk("press_lvl", int'(lvl_a), 1);
      chk("press_pend", q_a.size(), 0);

      sw_a = 1'b0;
      step(60);
      chk("release_lvl", int'(lvl_a), 0);

      bounce_a(14);
      step(60);
      chk("bounce0_lvl", int'(lvl_a), 0);

      bounce_a(13);
      f = cyc;
      push_a(f + 7, f + 15);
      step(60);
      chk("bounce1_lvl", int'(lvl_a), 1);
      chk("bounce1_pend", q_a.size(), 0);
      sw_a = 1'b0;
      step(60);
      chk("bounce1_rel_lvl", int'(lvl_a), 0);

      sw_a = 1'b1;
      step(8);
      rst_n = 1'b0;
      #1;
      chk("midrst_lvl", int'(lvl_a), 0);
      chk("midrst_trg", int'(trg_a), 0);
      step(2);
      release_rst();
      push_a(rel + 11, rel + 15);
      step(10);
      chk("midrst_early_lvl", int'(lvl_a), 0);
      step(20);
      chk("midrst_lvl_up", int'(lvl_a), 1);
      chk("midrst_pend", q_a.size(), 0);

      rst_n = 1'b0;
      #1;
      chk("async_rst_lvl", int'(lvl_a), 0);
      step(1);
      release_rst();
      push_a(rel + 11, rel + 15);
      step(20);
      chk("rerise_lvl", int'(lvl_a), 1);
      sw_a = 1'b0;
      step(60);
      chk("rerise_rel_lvl", int'(lvl_a), 0);

      sw_b = 1'b1;
      e = cyc;
      push_b(e + 3, e + 3);
      step(2);
      chk("b_lvl_pre", int'(lvl_b), 0);
      step(1);
      chk("b_lvl_rise", int'(lvl_b), 1);
      step(7);
      chk("b_pend", q_b.size(), 0);
      sw_b = 1'b0;
      step(5);
      chk("b_rel_lvl", int'(lvl_b), 0);

      sw_b = 1'b1;
      e = cyc;
      push_b(e + 3, e + 3);
      step(1);
      sw_b = 1'b0;
      step(2);
      chk("glitch_up", int'(lvl_b), 1);
      step(1);
      chk("glitch_down", int'(lvl_b), 0);
      step(5);
      chk("glitch_pend", q_b.size(), 0);

      sw_c = 1'b1;
      e = cyc;
      p = next_tick(e + 3) + 8;
      push_c(p, p);
      u = e + 100;
      fall_t = next_tick(u + 3) + 8;
`ifdef PULSE_REPEAT_EN
      for (int t = p + 20; t < fall_t; t += 8) push_c(t, t);
`endif
      step(100);
      chk("c_hold_lvl", int'(lvl_c), 1);
      sw_c = 1'b0;
      step(fall_t - cyc - 1);
      chk("c_fall_pre_lvl", int'(lvl_c), 1);
      step(1);
      chk("c_fall_lvl", int'(lvl_c), 0);
      step(40);
      chk("c_rel_lvl", int'(lvl_c), 0);
      chk("c_pend", q_c.size(), 0);

      chk("a_final_pend", q_a.size(), 0);
      chk("b_final_pend", q_b.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
